// File: rtl/bcd_pkg.sv
// Shared types for the BCD digit streamer: nibble type, digit limit, FSM states.
package bcd_pkg;

    typedef logic [3:0] nibble_t;

    localparam nibble_t BCD_MAX = 4'd9;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

endpackage : bcd_pkg

// File: rtl/bcd_digit_cell.sv
// One decimal digit register with carry/borrow chaining; clr has top priority.
// Carry/borrow outputs are combinational so a whole chain settles in one cycle.
module bcd_digit_cell
    import bcd_pkg::*;
(
    input  logic    clk,
    input  logic    rst_n,
    input  logic    clr,
    input  logic    carry_in,
    input  logic    borrow_in,
    output nibble_t digit,
    output logic    carry_out,
    output logic    borrow_out
);

    // Upstream logic never asserts carry_in and borrow_in together.
    assign carry_out  = carry_in  && (digit == BCD_MAX);
    assign borrow_out = borrow_in && (digit == 4'd0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            digit <= 4'd0;
        end else if (clr) begin
            digit <= 4'd0;
        end else if (carry_in) begin
            digit <= (digit == BCD_MAX) ? 4'd0 : digit + 4'd1;
        end else if (borrow_in) begin
            digit <= (digit == 4'd0) ? BCD_MAX : digit - 4'd1;
        end
    end

endmodule : bcd_digit_cell

// File: rtl/bcd_digit_streamer.sv
// NUM_DIGITS-digit BCD counter; each update snapshots the count and streams it LSD first.
// Latency: inc at edge n -> valid_o after edge n+1; frames hold on !ready_i and never abort.
// Optional BCD_STREAM_DOWN_EN adds dec/unf_o for down-counting with borrow.
module bcd_digit_streamer
    import bcd_pkg::*;
#(
    parameter int NUM_DIGITS = 2,
    parameter int IDX_W      = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    input  logic             clr,
`ifdef BCD_STREAM_DOWN_EN
    input  logic             dec,
    output logic             unf_o,
`endif
    output logic [3:0]       bcd_o,
    output logic [IDX_W-1:0] idx_o,
    output logic             last_o,
    output logic             valid_o,
    input  logic             ready_i,
    output logic             busy_o,
    output logic             ovf_o
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);

    logic                      up_step;
    logic                      dn_step;
    logic                      pend_set;
    logic [NUM_DIGITS:0]       carry;
    logic [NUM_DIGITS:0]       borrow;
    logic [4*NUM_DIGITS-1:0]   count_flat;

    state_t                    state, state_nxt;
    logic [IDX_W-1:0]          idx, idx_nxt;
    logic [4*NUM_DIGITS-1:0]   snap, snap_nxt;
    logic                      pend, pend_nxt;

    // Simultaneous up and down requests cancel out entirely: no step, no new frame.
`ifdef BCD_STREAM_DOWN_EN
    assign up_step = inc && !dec && !clr;
    assign dn_step = dec && !inc && !clr;
`else
    assign up_step = inc && !clr;
    assign dn_step = 1'b0;
`endif

    assign pend_set  = up_step || dn_step;
    assign carry[0]  = up_step;
    assign borrow[0] = dn_step;

    for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_digit
        nibble_t digit;

        bcd_digit_cell u_cell (
            .clk        (clk),
            .rst_n      (rst_n),
            .clr        (clr),
            .carry_in   (carry[g]),
            .borrow_in  (borrow[g]),
            .digit      (digit),
            .carry_out  (carry[g+1]),
            .borrow_out (borrow[g+1])
        );

        assign count_flat[4*g +: 4] = digit;
    end

    // A carry/borrow out of the top digit is exactly the all-9s/all-0s wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_o <= 1'b0;
        end else begin
            ovf_o <= carry[NUM_DIGITS];
        end
    end

`ifdef BCD_STREAM_DOWN_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            unf_o <= 1'b0;
        end else begin
            unf_o <= borrow[NUM_DIGITS];
        end
    end
`else
    logic unused_borrow;
    assign unused_borrow = borrow[NUM_DIGITS];
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            idx   <= '0;
            snap  <= '0;
            pend  <= 1'b0;
        end else begin
            state <= state_nxt;
            idx   <= idx_nxt;
            snap  <= snap_nxt;
            pend  <= pend_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        snap_nxt  = snap;
        pend_nxt  = pend || pend_set;

        case (state)
            IDLE: begin
                if (pend) begin
                    // Load the registered count; a step on this same edge re-arms pend.
                    snap_nxt  = count_flat;
                    pend_nxt  = pend_set;
                    idx_nxt   = '0;
                    state_nxt = SEND;
                end
            end
            SEND: begin
                if (ready_i) begin
                    if (idx == LAST_IDX) begin
                        state_nxt = IDLE;
                    end else begin
                        idx_nxt = idx + 1'b1;
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign valid_o = (state == SEND);
    assign busy_o  = (state == SEND);
    assign idx_o   = idx;
    assign last_o  = valid_o && (idx == LAST_IDX);

    always_comb begin
        bcd_o = 4'd0;
        if (valid_o) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                if (idx == IDX_W'(i)) begin
                    bcd_o = snap[4*i +: 4];
                end
            end
        end
    end

endmodule : bcd_digit_streamer

// File: tb/tb_bcd_digit_streamer.sv
// Bench for bcd_digit_streamer (NUM_DIGITS=2): vector table plus handwritten corner sequences.
module tb_bcd_digit_streamer;

    logic       clk;
    logic       rst_n;
    logic       inc;
    logic       clr;
    logic [3:0] bcd_o;
    logic [2:0] idx_o;
    logic       last_o;
    logic       valid_o;
    logic       ready_i;
    logic       busy_o;
    logic       ovf_o;
`ifdef BCD_STREAM_DOWN_EN
    logic       dec;
    logic       unf_o;
`endif

    bcd_digit_streamer #(.NUM_DIGITS(2), .IDX_W(3)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .inc     (inc),
        .clr     (clr),
`ifdef BCD_STREAM_DOWN_EN
        .dec     (dec),
        .unf_o   (unf_o),
`endif
        .bcd_o   (bcd_o),
        .idx_o   (idx_o),
        .last_o  (last_o),
        .valid_o (valid_o),
        .ready_i (ready_i),
        .busy_o  (busy_o),
        .ovf_o   (ovf_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] bcd;
        logic [2:0] idx;
        logic       last;
    } exp_t;

    typedef struct {
        int         start;
        logic [3:0] d0;
        logic [3:0] d1;
        logic       ovf;
    } vec_t;

    exp_t q[$];
    vec_t vecs[6];
    int   checks = 0;
    int   errors = 0;
    bit   sb_en  = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard: a handshake is taken at the coming posedge when valid && ready now.
    task automatic mon();
        exp_t e;
        if (sb_en && valid_o && ready_i) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_digit: got bcd=%0d idx=%0d with empty queue at %0t",
                         bcd_o, idx_o, $time);
            end else begin
                e = q.pop_front();
                chk("sb_bcd", int'(bcd_o), int'(e.bcd));
                chk("sb_idx", int'(idx_o), int'(e.idx));
                chk("sb_last", int'(last_o), int'(e.last));
            end
        end
    endtask

    task automatic tick();
        mon();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic push_frame(input logic [3:0] d0, input logic [3:0] d1);
        q.push_back('{bcd: d0, idx: 3'd0, last: 1'b0});
        q.push_back('{bcd: d1, idx: 3'd1, last: 1'b1});
    endtask

    task automatic wait_idle(input int budget);
        int quiet = 0;
        int n = 0;
        while (quiet < 3 && n < budget) begin
            tick();
            n++;
            quiet = busy_o ? 0 : quiet + 1;
        end
        if (quiet < 3) chk("wait_idle_timeout", 1, 0);
    endtask

    task automatic wait_q(input int budget);
        int n = 0;
        while (q.size() > 0 && n < budget) begin
            tick();
            n++;
        end
        if (q.size() > 0) begin
            chk("wait_frame_timeout", q.size(), 0);
            q.delete();
        end
    endtask

    // Bring the counter to v with the scoreboard off, then re-enable it once quiet.
    task automatic set_count(input int v);
        sb_en   = 1'b0;
        ready_i = 1'b1;
        clr     = 1'b1;
        tick();
        clr = 1'b0;
        for (int k = 0; k < v; k++) begin
            inc = 1'b1;
            tick();
        end
        inc = 1'b0;
        wait_idle(50);
        sb_en = 1'b1;
    endtask

    initial begin
        vecs[0] = '{start: 0,  d0: 4'd1, d1: 4'd0, ovf: 1'b0};
        vecs[1] = '{start: 8,  d0: 4'd9, d1: 4'd0, ovf: 1'b0};
        vecs[2] = '{start: 9,  d0: 4'd0, d1: 4'd1, ovf: 1'b0};
        vecs[3] = '{start: 36, d0: 4'd7, d1: 4'd3, ovf: 1'b0};
        vecs[4] = '{start: 98, d0: 4'd9, d1: 4'd9, ovf: 1'b0};
        vecs[5] = '{start: 99, d0: 4'd0, d1: 4'd0, ovf: 1'b1};

        rst_n   = 1'b0;
        inc     = 1'b0;
        clr     = 1'b0;
        ready_i = 1'b1;
`ifdef BCD_STREAM_DOWN_EN
        dec     = 1'b0;
`endif
        @(negedge clk);
        for (int k = 0; k < 3; k++) tick();
        chk("rst_valid", int'(valid_o), 0);
        chk("rst_bcd", int'(bcd_o), 0);
        chk("rst_idx", int'(idx_o), 0);
        chk("rst_last", int'(last_o), 0);
        chk("rst_busy", int'(busy_o), 0);
        chk("rst_ovf", int'(ovf_o), 0);
        rst_n = 1'b1;
        sb_en = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("idle_no_valid", int'(valid_o), 0);
        end

        // Single increment from each start value: latency, digits, wrap pulse.
        for (int i = 0; i < 6; i++) begin
            set_count(vecs[i].start);
            push_frame(vecs[i].d0, vecs[i].d1);
            inc = 1'b1;
            tick();
            inc = 1'b0;
            chk("lat_valid_edge_n", int'(valid_o), 0);
            chk("ovf_pulse", int'(ovf_o), int'(vecs[i].ovf));
            tick();
            chk("lat_valid_edge_n1", int'(valid_o), 1);
            chk("lat_busy", int'(busy_o), 1);
            chk("ovf_one_cycle", int'(ovf_o), 0);
            wait_q(20);
            chk("valid_after_frame", int'(valid_o), 0);
        end

        // Backpressure on the frame for 37.
        set_count(36);
        ready_i = 1'b0;
        push_frame(4'd7, 4'd3);
        inc = 1'b1;
        tick();
        inc = 1'b0;
        tick();
        for (int k = 0; k < 5; k++) begin
            chk("bp_valid", int'(valid_o), 1);
            chk("bp_bcd", int'(bcd_o), 7);
            chk("bp_idx", int'(idx_o), 0);
            tick();
        end
        ready_i = 1'b1;
        wait_q(20);
        wait_idle(20);

        // Coalescing: three incs while the 05 frame is stalled give one 08 frame.
        set_count(4);
        push_frame(4'd5, 4'd0);
        push_frame(4'd8, 4'd0);
        inc = 1'b1;
        tick();
        inc     = 1'b0;
        ready_i = 1'b0;
        tick();
        chk("coal_frame_loaded", int'(valid_o), 1);
        inc = 1'b1;
        for (int k = 0; k < 3; k++) tick();
        inc     = 1'b0;
        ready_i = 1'b1;
        wait_q(30);
        wait_idle(30);
        chk("coal_queue_empty", q.size(), 0);

        // clr during SEND leaves the in-flight frame intact and zeroes the counter.
        set_count(36);
        push_frame(4'd7, 4'd3);
        ready_i = 1'b0;
        inc = 1'b1;
        tick();
        inc = 1'b0;
        tick();
        clr = 1'b1;
        tick();
        clr     = 1'b0;
        ready_i = 1'b1;
        wait_q(20);
        wait_idle(20);
        push_frame(4'd1, 4'd0);
        inc = 1'b1;
        tick();
        inc = 1'b0;
        wait_q(20);

`ifdef BCD_STREAM_DOWN_EN
        // Underflow from 00 streams 99.
        set_count(0);
        push_frame(4'd9, 4'd9);
        dec = 1'b1;
        tick();
        dec = 1'b0;
        chk("unf_pulse", int'(unf_o), 1);
        tick();
        chk("unf_one_cycle", int'(unf_o), 0);
        wait_q(20);
        wait_idle(20);
        // inc and dec together: no step, no frame; counter still 99.
        inc = 1'b1;
        dec = 1'b1;
        tick();
        inc = 1'b0;
        dec = 1'b0;
        chk("incdec_no_ovf", int'(ovf_o), 0);
        chk("incdec_no_unf", int'(unf_o), 0);
        wait_idle(20);
        push_frame(4'd0, 4'd0);
        inc = 1'b1;
        tick();
        inc = 1'b0;
        chk("incdec_then_wrap", int'(ovf_o), 1);
        wait_q(20);
`endif

        // Asynchronous reset mid-frame drops valid_o at once.
        set_count(10);
        sb_en = 1'b0;
        inc = 1'b1;
        tick();
        inc = 1'b0;
        tick();
        chk("pre_reset_valid", int'(valid_o), 1);
        rst_n = 1'b0;
        #1;
        chk("async_reset_valid", int'(valid_o), 0);
        chk("async_reset_busy", int'(busy_o), 0);
        q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_bcd_digit_streamer

// File: doc/bcd_digit_streamer.md
Name: bcd_digit_streamer

Overview:
- Upstream source for the BCD-to-Excess-3 conversion stage.
- Holds a NUM_DIGITS-digit decimal (BCD) counter.
- On every count update, snapshots the count and streams its digits, least-significant digit first, as 4-bit BCD nibbles over a valid/ready interface.
- The downstream converter consumes one legal BCD code (0-9) per accepted transfer.

Parameters:
- NUM_DIGITS, 2, number of BCD digits in the counter and in each streamed frame (range 1-8).
- IDX_W, 3, width of the digit index output; must satisfy 2**IDX_W >= NUM_DIGITS.

Ports:
- clk  input  1  single system clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- inc  input  1  increment request, sampled each rising edge.
- clr  input  1  synchronous clear of the counter.
- bcd_o  output  4  streamed digit; bit3=A (MSB) ... bit0=D (LSB); always 0-9.
- idx_o  output  IDX_W  index of the digit on bcd_o (0 = least significant).
- last_o  output  1  high when idx_o == NUM_DIGITS-1 and valid_o is high.
- valid_o  output  1  bcd_o/idx_o/last_o are valid.
- ready_i  input  1  downstream accepts the digit when valid_o && ready_i.
- busy_o  output  1  high while a frame is in flight (state SEND).
- ovf_o  output  1  one-cycle pulse on wrap from all-9s to all-0s.

Behaviour:
- Reset is asynchronous, active-low, with one clock clk. While rst_n=0:
  - counter = 0, snapshot = 0, pend = 0, state = IDLE.
  - valid_o = 0, bcd_o = 0, idx_o = 0, last_o = 0, busy_o = 0, ovf_o = 0.
- Counter:
  - Each digit counts 0..9.
  - An increment adds 1 to digit 0; a digit at 9 becomes 0 and carries into the next digit.
  - Digit values 10-15 are unreachable and never output.
- Priority: clr > inc.
  - clr: counter <= 0; pend is not changed; any frame in flight is not aborted.
  - inc (clr=0): counter <= counter+1 and pend <= 1.
  - Wrap from all-9s: counter <= 0 and ovf_o = 1 for exactly that one cycle.
- pend is a one-deep coalescing request.
  - Multiple incs during a frame produce one following frame.
  - That frame carries the newest count, sampled when the frame is loaded.
- FSM states are IDLE and SEND.
  - IDLE: if pend=1, snapshot <= counter (the registered value, already incremented), pend <= 0 (unless inc in the same cycle, which keeps pend=1), idx <= 0, valid_o <= 1, go to SEND. Otherwise stay in IDLE.
  - SEND: valid_o=1, bcd_o = snapshot digit[idx]. Outputs are held stable until the handshake.
  - On valid_o && ready_i with idx < NUM_DIGITS-1: idx++.
  - On valid_o && ready_i with idx == NUM_DIGITS-1: valid_o <= 0 and go to IDLE.
  - IDLE with pend already set at that edge begins the next frame one cycle later; there is always one idle cycle between frames.
- Latency:
  - inc sampled at edge n → counter updated and pend set at edge n.
  - valid_o rises after edge n+1.
  - With ready_i held high, one digit per cycle; a frame takes NUM_DIGITS cycles.
- valid_o never drops without a handshake. ready_i may toggle freely.
- Reset mid-frame: valid_o drops immediately (asynchronously); the frame is lost.

Optional Feature:
- Macro: BCD_STREAM_DOWN_EN.
- Defined:
  - Adds input dec (1 bit) and output unf_o (1 bit).
  - dec subtracts 1 with borrow: digit 0 becomes 9 and borrows.
  - All-0s minus 1 gives all-9s and pulses unf_o for one cycle.
  - dec sets pend, like inc.
  - inc && dec together (clr=0): counter unchanged, pend unchanged, no pulse.
  - clr still has top priority.
- Not defined: no dec/unf_o ports; counting is up-only.

Decomposition:
- Shared package bcd_pkg:
  - Nibble typedef (4 bits).
  - BCD_MAX = 4'd9.
  - FSM state enum {IDLE, SEND}.
- Sub-module bcd_digit_cell:
  - One digit register with inc/dec/clr, carry/borrow in and carry/borrow out.
  - Instantiated NUM_DIGITS times in a generate chain.

Test Plan (NUM_DIGITS=2 unless noted):
- Reset with rst_n low for 3 cycles, then release → all outputs 0; no valid_o without inc.
- Single inc from 00, ready_i=1 → valid_o rises 2 edges later; frames {bcd=1,idx=0}, {bcd=0,idx=1,last=1}; valid_o then 0.
- Counter at 99, inc → ovf_o pulses for 1 cycle; streamed frame is 0,0.
- Backpressure: frame for 37 with ready_i=0 for 5 cycles → bcd_o=7, idx_o=0 held stable; after ready_i=1, digits 7 then 3 are delivered.
- Coalescing: 3 incs during a frame starting at 05 → exactly one following frame carrying 08. clr during SEND → current frame still completes with its snapshot values.
- Macro defined: from 00, dec → unf_o pulses and frame 9,9 is streamed. inc and dec together → no frame, counter unchanged.
